toggle_pulse_gen: RTL and testbench

Upstream conditioning stage for the reset/toggle flip-flop: turns a raw, asynchronous, bouncing push-button level into clean single-cycle toggle pulses on `t`. Adds a wrapping press counter and, optionally, hold-to-repeat. The `t` output drives the flip-flop's toggle input directly, one pulse per debounced press.

---
 rtl/toggle_pkg.sv | 24 ++
 rtl/sync2.sv | 21 ++
 rtl/toggle_pulse_gen.sv | 123 ++++++++++++
 tb/tb_toggle_pulse_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and defaults for the push-button toggle pulse generator.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } tpg_state_t;

    localparam int unsigned DEF_DEB_CYCLES = 4;
    localparam int unsigned DEF_REP_CYCLES = 16;
    localparam int unsigned DEF_CNT_W      = 8;

    // Timer must hold counts up to the larger of the two periods, at least one bit.
    function automatic int unsigned tmr_width(input int unsigned deb, input int unsigned rep);
        int unsigned m;
        int unsigned w;
        m = (deb > rep) ? deb : rep;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw push-button into single-cycle toggle pulses with a wrapping press counter.
// Optional hold-to-repeat is enabled by defining TOGGLE_AUTOREPEAT_EN.
module toggle_pulse_gen #(
    parameter int unsigned DEB_CYCLES = toggle_pkg::DEF_DEB_CYCLES,
    parameter int unsigned REP_CYCLES = toggle_pkg::DEF_REP_CYCLES,
    parameter int unsigned CNT_W      = toggle_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    output logic             t,
    output logic             btn_db,
    output logic [CNT_W-1:0] cnt
);

    import toggle_pkg::*;

    localparam int unsigned     TMR_W    = tmr_width(DEB_CYCLES, REP_CYCLES);
    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_CYCLES - 1);
`ifdef TOGGLE_AUTOREPEAT_EN
    localparam logic [TMR_W-1:0] REP_LAST = TMR_W'(REP_CYCLES - 1);
`endif

    logic             btn_s;
    tpg_state_t       state;
    tpg_state_t       state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             t_nxt;
    logic             btn_db_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .q     (btn_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tmr    <= '0;
            t      <= 1'b0;
            btn_db <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            t      <= t_nxt;
            btn_db <= btn_db_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        t_nxt     = 1'b0;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else if (tmr == DEB_LAST) begin
                    state_nxt = HELD;
                    tmr_nxt   = '0;
                    t_nxt     = 1'b1;
                    cnt_nxt   = cnt + CNT_W'(1);
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    tmr_nxt   = '0;
                end else begin
`ifdef TOGGLE_AUTOREPEAT_EN
                    // A repeat landing right after a pulse is dropped so pulses never abut.
                    if (tmr == REP_LAST) begin
                        tmr_nxt = '0;
                        if (!t) begin
                            t_nxt   = 1'b1;
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
`else
                    tmr_nxt = '0;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nxt = HELD;
                    tmr_nxt   = '0;
                end else if (tmr == DEB_LAST) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase

        btn_db_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench: expected pulse edges and counts are queued as the button is driven.
module tb_toggle_pulse_gen;

    localparam int DEB = 4;
    localparam int REP = 16;

    typedef struct {
        int e;
        int c;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       t;
    logic       btn_db;
    logic [7:0] cnt;
    logic       t_w;
    logic       btn_db_w;
    logic [1:0] cnt_w;

    int   ecnt;
    int   n_chk;
    int   n_fail;
    int   cnt_exp;
    exp_t sb[$];

    toggle_pulse_gen #(.DEB_CYCLES(DEB), .REP_CYCLES(REP), .CNT_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .t      (t),
        .btn_db (btn_db),
        .cnt    (cnt)
    );

    toggle_pulse_gen #(.DEB_CYCLES(DEB), .REP_CYCLES(REP), .CNT_W(2)) dut_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .t      (t_w),
        .btn_db (btn_db_w),
        .cnt    (cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    task automatic push(input int e);
        exp_t x;
        cnt_exp++;
        x.e = e;
        x.c = cnt_exp;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        btn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Clean hold of n sampled cycles starting at the next edge.
    task automatic press(input int n);
        int e0;
        @(negedge clk);
        btn = 1'b1;
        e0  = ecnt + 1;
        if (n >= DEB + 1) push(e0 + DEB + 2);
`ifdef TOGGLE_AUTOREPEAT_EN
        for (int j = 1; DEB + 1 + REP * j <= n; j++) push(e0 + DEB + 2 + REP * j);
`endif
        repeat (n) @(negedge clk);
        btn = 1'b0;
    endtask

    // Every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && t) begin
            if (sb.size() == 0) begin
                chk("t_spurious", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("t_edge", ecnt, x.e);
                chk("cnt_at_t", int'(cnt), x.c % 256);
                chk("cnt_w_at_t", int'(cnt_w), x.c % 4);
                chk("btn_db_at_t", int'(btn_db), 1);
                chk("t_w_at_t", int'(t_w), 1);
            end
        end
    end

    initial begin
        int e0;
        ecnt    = 0;
        n_chk   = 0;
        n_fail  = 0;
        cnt_exp = 0;
        btn     = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_t", int'(t), 0);
        chk("rst_btn_db", int'(btn_db), 0);
        chk("rst_cnt", int'(cnt), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // clean press
        press(20);
        chk("held_btn_db", int'(btn_db), 1);
        idle(10);
        chk("clean_cnt", int'(cnt), cnt_exp);
        chk("clean_release_db", int'(btn_db), 0);

        // press bounce shorter than debounce window
        press(3);
        idle(3);
        chk("bounce_db", int'(btn_db), 0);
        idle(10);
        chk("bounce_cnt", int'(cnt), cnt_exp);

        // low glitch while held, then full release and re-press
        @(negedge clk);
        btn = 1'b1;
        e0  = ecnt + 1;
        push(e0 + DEB + 2);
        repeat (12) @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_db", int'(btn_db), 1);
        idle(10);
        chk("glitch_cnt", int'(cnt), cnt_exp);
        press(8);
        idle(10);
        chk("repress_cnt", int'(cnt), cnt_exp);

        // long hold: repeats only when the feature is built in
        press(60);
        idle(10);
        chk("hold_cnt", int'(cnt), cnt_exp);

        // asynchronous reset while held, button kept pressed through release
        @(negedge clk);
        btn = 1'b1;
        e0  = ecnt + 1;
        push(e0 + DEB + 2);
        repeat (10) @(negedge clk);
        chk("pre_rst_cnt", int'(cnt), cnt_exp);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_t", int'(t), 0);
        chk("mid_rst_cnt", int'(cnt), 0);
        chk("mid_rst_btn_db", int'(btn_db), 0);
        chk("mid_rst_cnt_w", int'(cnt_w), 0);
        cnt_exp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0    = ecnt + 1;
        push(e0 + DEB + 2);
        repeat (10) @(negedge clk);
        idle(10);
        chk("post_rst_cnt", int'(cnt), cnt_exp);

        // counter wrap on the 2-bit instance
        @(negedge clk);
        rst_n   = 1'b0;
        cnt_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            press(8);
            idle(10);
        end
        chk("wrap_cnt_w", int'(cnt_w), 1);
        chk("wrap_cnt", int'(cnt), 5);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
